fft_pass_sequencer: RTL and testbench

- Top-level scheduler for the mixed-radix FFT datapath, N = 2^a·3^b·5^c ≤ 2048.
- Owns a single in-place sample memory and sequences the frame: LOAD, then radix-5, radix-3 and radix-2 passes, then UNLOAD.
- Generates memory read/write addresses, selects the active radix engine and counts engine outputs to detect pass completion.
- Replaces the ad hoc per-engine address counters and pulse-counting glue.

---
 rtl/fft_ctrl_pkg.sv | 24 ++
 rtl/stride_addr_gen.sv | 49 ++++
 rtl/fft_pass_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fft_pass_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared constants, engine encodings and controller state type for the FFT pass sequencer.
package fft_ctrl_pkg;

    localparam int ADDR_W = 11;
    localparam int MAX_N  = 2048;

    localparam logic [1:0] ENG_NONE = 2'b00;
    localparam logic [1:0] ENG_R5   = 2'b01;
    localparam logic [1:0] ENG_R3   = 2'b10;
    localparam logic [1:0] ENG_R2   = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD, PASS_RD, PASS_DRAIN, UNLOAD} state_t;

    // base**e for small exponents; the loop bound is fixed so it unrolls in synthesis
    function automatic logic [31:0] ipow(input logic [31:0] base, input logic [3:0] e);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(e)) r = r * base;
        end
        return r;
    endfunction

endpackage

// File: rtl/stride_addr_gen.sv
// Strided address walker: addr = t + e*stride, e fastest over 0..len-1, built from adders only.
module stride_addr_gen #(
    parameter int ADDR_W = fft_ctrl_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W:0]   stride,
    input  logic [ADDR_W:0]   total,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] e;
    logic [ADDR_W-1:0] t;
    logic [ADDR_W-1:0] cnt;
    logic              e_wrap;

    assign e_wrap = ({1'b0, e} == len - (ADDR_W+1)'(1));
    assign last   = ({1'b0, cnt} == total - (ADDR_W+1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e    <= '0;
            t    <= '0;
            addr <= '0;
            cnt  <= '0;
        end else if (clear) begin
            e    <= '0;
            t    <= '0;
            addr <= '0;
            cnt  <= '0;
        end else if (step) begin
            cnt <= cnt + ADDR_W'(1);
            // end of a butterfly group: next group starts one word further on
            if (e_wrap) begin
                e    <= '0;
                t    <= t + ADDR_W'(1);
                addr <= t + ADDR_W'(1);
            end else begin
                e    <= e + ADDR_W'(1);
                addr <= ADDR_W'({1'b0, addr} + stride);
            end
        end
    end

endmodule

// File: rtl/fft_pass_sequencer.sv
// Frame scheduler for the mixed-radix FFT: load, r5/r3/r2 in-place passes, unload.
module fft_pass_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int ADDR_W = fft_ctrl_pkg::ADDR_W,
    parameter int MAX_N  = fft_ctrl_pkg::MAX_N,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [3:0]        stages2,
    input  logic [2:0]        stages3,
    input  logic [1:0]        stages5,
    output logic              cfg_ready,
    output logic              cfg_err,
    input  logic              abort,
    input  logic              in_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [1:0]        eng_sel,
    output logic              eng_di_en,
    input  logic              eng_do_en,
    output logic              busy,
    output logic              out_valid,
    output logic              out_last,
    output logic [1:0]        pass_idx
);

    localparam int CW = ADDR_W + 1;

    state_t          state;
    logic [1:0]      cur_eng;
    logic [1:0]      nxt_eng;
    logic [CW-1:0]   pow2_r, pow3_r, pow5_r, n_r, s5_r, s3_r, s2_r;
    logic            rd_done, wr_done;
    logic [RD_LAT-1:0] di_pipe, ov_pipe, ol_pipe;

    logic [31:0]     p2_c, p3_c, p5_c, n_c;
    logic [CW-1:0]   gen_len, gen_stride;
    logic            in_pass, rd_step, wr_step;
    logic            load_done, wr_fin, drain_done, gen_clear;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic            rd_last, wr_last;

    // 32-bit products so oversized requests cannot wrap into the legal range
    assign p2_c = 32'd1 << stages2;
    assign p3_c = ipow(32'd3, {1'b0, stages3});
    assign p5_c = ipow(32'd5, {2'b00, stages5});
    assign n_c  = p2_c * p3_c * p5_c;

    assign in_pass    = (state == PASS_RD) || (state == PASS_DRAIN);
    assign rd_step    = (state == PASS_RD) || ((state == UNLOAD) && !rd_done);
    assign wr_step    = ((state == LOAD) && in_valid) || (in_pass && eng_do_en);
    assign load_done  = (state == LOAD) && in_valid && wr_last;
    assign wr_fin     = in_pass && eng_do_en && wr_last;
    assign drain_done = (state == PASS_DRAIN) && (wr_done || wr_fin);
    assign gen_clear  = abort || (state == IDLE) || load_done || drain_done;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mem_re    = rd_step;
    assign mem_we    = wr_step;
    assign mem_raddr = rd_step ? rd_addr : '0;
    assign mem_waddr = wr_step ? wr_addr : '0;
    assign eng_sel   = cur_eng;
    assign pass_idx  = (state == UNLOAD) ? 2'd3 : cur_eng;
    assign eng_di_en = di_pipe[RD_LAT-1];
    assign out_valid = ov_pipe[RD_LAT-1];
    assign out_last  = ol_pipe[RD_LAT-1];

    // load and unload walk linearly: one-element groups spaced by N
    always_comb begin
        gen_len    = CW'(1);
        gen_stride = n_r;
        if (in_pass) begin
            case (cur_eng)
                ENG_R5:  begin gen_len = pow5_r; gen_stride = s5_r; end
                ENG_R3:  begin gen_len = pow3_r; gen_stride = s3_r; end
                default: begin gen_len = pow2_r; gen_stride = s2_r; end
            endcase
        end
    end

    always_comb begin
        nxt_eng = ENG_NONE;
        if ((cur_eng == ENG_NONE) && (pow5_r != CW'(1)))
            nxt_eng = ENG_R5;
        else if (((cur_eng == ENG_NONE) || (cur_eng == ENG_R5)) && (pow3_r != CW'(1)))
            nxt_eng = ENG_R3;
        else if ((cur_eng != ENG_R2) && (pow2_r != CW'(1)))
            nxt_eng = ENG_R2;
    end

    stride_addr_gen #(.ADDR_W(ADDR_W)) u_rd_gen (
        .clk(clk), .rst(rst), .clear(gen_clear), .step(rd_step),
        .len(gen_len), .stride(gen_stride), .total(n_r),
        .addr(rd_addr), .last(rd_last)
    );

    stride_addr_gen #(.ADDR_W(ADDR_W)) u_wr_gen (
        .clk(clk), .rst(rst), .clear(gen_clear), .step(wr_step),
        .len(gen_len), .stride(gen_stride), .total(n_r),
        .addr(wr_addr), .last(wr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_eng <= ENG_NONE;
            cfg_err <= 1'b0;
            rd_done <= 1'b0;
            wr_done <= 1'b0;
            di_pipe <= '0;
            ov_pipe <= '0;
            ol_pipe <= '0;
            pow2_r  <= '0;
            pow3_r  <= '0;
            pow5_r  <= '0;
            n_r     <= '0;
            s5_r    <= '0;
            s3_r    <= '0;
            s2_r    <= '0;
        end else begin
            cfg_err <= 1'b0;
            di_pipe <= (di_pipe << 1) | RD_LAT'(state == PASS_RD);
            ov_pipe <= (ov_pipe << 1) | RD_LAT'((state == UNLOAD) && rd_step);
            ol_pipe <= (ol_pipe << 1) | RD_LAT'((state == UNLOAD) && rd_step && rd_last);
            if (abort) begin
                state   <= IDLE;
                cur_eng <= ENG_NONE;
                rd_done <= 1'b0;
                wr_done <= 1'b0;
                di_pipe <= '0;
                ov_pipe <= '0;
                ol_pipe <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_valid) begin
                            if (n_c > 32'(MAX_N)) begin
                                cfg_err <= 1'b1;
                            end else begin
                                pow2_r  <= CW'(p2_c);
                                pow3_r  <= CW'(p3_c);
                                pow5_r  <= CW'(p5_c);
                                n_r     <= CW'(n_c);
                                s5_r    <= CW'(p2_c * p3_c);
                                s3_r    <= CW'(p2_c * p5_c);
                                s2_r    <= CW'(p3_c * p5_c);
                                cur_eng <= ENG_NONE;
                                rd_done <= 1'b0;
                                wr_done <= 1'b0;
                                state   <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (load_done) begin
                            cur_eng <= nxt_eng;
                            state   <= (nxt_eng == ENG_NONE) ? UNLOAD : PASS_RD;
                        end
                    end
                    PASS_RD: begin
                        if (wr_fin) wr_done <= 1'b1;
                        if (rd_step && rd_last) state <= PASS_DRAIN;
                    end
                    PASS_DRAIN: begin
                        if (drain_done) begin
                            wr_done <= 1'b0;
                            cur_eng <= nxt_eng;
                            state   <= (nxt_eng == ENG_NONE) ? UNLOAD : PASS_RD;
                        end
                    end
                    UNLOAD: begin
                        if (rd_step && rd_last) rd_done <= 1'b1;
                        // leave once the final beat has emerged from the read pipeline
                        if (ol_pipe[RD_LAT-1]) begin
                            rd_done <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_pass_sequencer.sv
// Bench for fft_pass_sequencer: directed and randomized frames against a loop-based address model.
module tb_fft_pass_sequencer;

    localparam int ADDR_W = 11;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic [3:0]        stages2 = '0;
    logic [2:0]        stages3 = '0;
    logic [1:0]        stages5 = '0;
    logic              cfg_ready, cfg_err;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [1:0]        eng_sel;
    logic              eng_di_en;
    logic              eng_do_en = 1'b0;
    logic              busy, out_valid, out_last;
    logic [1:0]        pass_idx;

    fft_pass_sequencer #(.ADDR_W(ADDR_W), .MAX_N(2048), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid),
        .stages2(stages2), .stages3(stages3), .stages5(stages5),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .abort(abort), .in_valid(in_valid),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_re(mem_re), .mem_raddr(mem_raddr),
        .eng_sel(eng_sel), .eng_di_en(eng_di_en), .eng_do_en(eng_do_en), .busy(busy),
        .out_valid(out_valid), .out_last(out_last), .pass_idx(pass_idx)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int d_lat    = 1;
    int cyc      = 0;
    logic [15:0] hist = '0;
    int wlog[$], wcyc[$], rlog[$], rcyc[$], dcyc[$], ocyc[$], bq[$], drq[$];
    bit olast[$];

    // Passive observer on the falling edge; also feeds the engine loopback history.
    always @(negedge clk) begin
        cyc  <= cyc + 1;
        hist <= {hist[14:0], eng_di_en};
        if (mem_we) begin wlog.push_back(int'(eng_sel) * 4096 + int'(mem_waddr)); wcyc.push_back(cyc); end
        if (mem_re) begin rlog.push_back(int'(eng_sel) * 4096 + int'(mem_raddr)); rcyc.push_back(cyc); end
        if (eng_di_en) dcyc.push_back(cyc);
        if (out_valid) begin ocyc.push_back(cyc); olast.push_back(out_last); end
        if (busy) bq.push_back(cyc);
        if (busy && eng_sel != 2'b00 && !mem_re) drq.push_back(cyc);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Engine model: echoes eng_di_en back as eng_do_en d_lat cycles later.
    task automatic tick();
        @(posedge clk);
        #1;
        eng_do_en = hist[d_lat-1];
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); rlog.delete(); rcyc.delete();
        dcyc.delete(); ocyc.delete(); olast.delete(); bq.delete(); drq.delete();
    endtask

    function automatic int ipow_tb(input int base, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * base;
        return r;
    endfunction

    task automatic start_cfg(input int a, input int b, input int c);
        stages2 = 4'(a); stages3 = 3'(b); stages5 = 2'(c);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_load(input int n, input bit gappy, input bit junky, output int lcyc);
        int loads = 0;
        lcyc = 0;
        while (loads < n && lcyc < 20000) begin
            in_valid  = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
            cfg_valid = junky ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cfg_valid) stages2 = 4'($urandom_range(0, 15));
            tick();
            if (in_valid) loads++;
            lcyc++;
            if (junky && loads < n) eng_do_en = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit junky);
        int k = 0;
        while (busy && k < 30000) begin
            in_valid = junky ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            k++;
        end
        in_valid = 1'b0;
        chk({tag, "/idle_at_end"}, busy, 0);
    endtask

    task automatic check_frame(input string tag, input int a, input int b, input int c,
                               input int d, input int lcyc);
        int pl[3];
        int ew[$], er[$];
        int n, np, s, m, idx, nl;
        pl[0] = ipow_tb(5, c); pl[1] = ipow_tb(3, b); pl[2] = ipow_tb(2, a);
        n  = pl[0] * pl[1] * pl[2];
        np = 0;
        for (int k = 0; k < n; k++) ew.push_back(k);
        for (int q = 0; q < 3; q++) begin
            if (pl[q] > 1) begin
                np++;
                s = n / pl[q];
                for (int t = 0; t < s; t++)
                    for (int e = 0; e < pl[q]; e++) begin
                        ew.push_back((q + 1) * 4096 + t + e * s);
                        er.push_back((q + 1) * 4096 + t + e * s);
                    end
            end
        end
        for (int k = 0; k < n; k++) er.push_back(k);

        chk({tag, "/wr_count"}, wlog.size(), ew.size());
        m = 0;
        foreach (ew[i]) if (i < wlog.size() && wlog[i] == ew[i]) m++;
        chk({tag, "/wr_order_matches"}, m, ew.size());
        chk({tag, "/rd_count"}, rlog.size(), er.size());
        m = 0;
        foreach (er[i]) if (i < rlog.size() && rlog[i] == er[i]) m++;
        chk({tag, "/rd_order_matches"}, m, er.size());

        if (np > 0) begin
            m = 0;
            for (int i = 0; i < np * n; i++)
                if (n + i < wcyc.size() && i < rcyc.size() && wcyc[n+i] == rcyc[i] + RD_LAT + d) m++;
            chk({tag, "/wr_lag_matches"}, m, np * n);
            m = 0;
            for (int i = 0; i < np * n; i++)
                if (i < dcyc.size() && i < rcyc.size() && dcyc[i] == rcyc[i] + RD_LAT) m++;
            chk({tag, "/di_lag_matches"}, m, np * n);
        end
        chk({tag, "/di_count"}, dcyc.size(), np * n);

        chk({tag, "/out_count"}, ocyc.size(), n);
        m = 0;
        for (int i = 0; i < n; i++)
            if (i < ocyc.size() && np * n + i < rcyc.size() && ocyc[i] == rcyc[np*n+i] + RD_LAT) m++;
        chk({tag, "/out_lag_matches"}, m, n);
        idx = -1; nl = 0;
        foreach (olast[i]) if (olast[i]) begin nl++; if (idx < 0) idx = i; end
        chk({tag, "/out_last_idx"}, idx, n - 1);
        chk({tag, "/out_last_cnt"}, nl, 1);

        chk({tag, "/busy_cycles"}, bq.size(), lcyc + np * (n + RD_LAT + d) + n + RD_LAT);
        chk({tag, "/drain_cycles"}, drq.size(), np * (RD_LAT + d));
    endtask

    task automatic run_frame(input string tag, input int a, input int b, input int c,
                             input int d, input bit gappy, input bit junky);
        int n, lcyc;
        n = ipow_tb(2, a) * ipow_tb(3, b) * ipow_tb(5, c);
        d_lat = d;
        clear_logs();
        start_cfg(a, b, c);
        chk({tag, "/busy_after_cfg"}, busy, 1);
        do_load(n, gappy, junky, lcyc);
        wait_idle(tag, junky);
        check_frame(tag, a, b, c, d, lcyc);
        tick();
    endtask

    task automatic reject(input string tag, input int a, input int b, input int c);
        stages2 = 4'(a); stages3 = 3'(b); stages5 = 2'(c);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk({tag, "/cfg_err_pulse"}, cfg_err, 1);
        chk({tag, "/cfg_ready"}, cfg_ready, 1);
        chk({tag, "/busy"}, busy, 0);
        tick();
        chk({tag, "/cfg_err_cleared"}, cfg_err, 0);
        chk({tag, "/busy_later"}, busy, 0);
        chk({tag, "/no_write"}, mem_we, 0);
    endtask

    initial begin
        int k, a, b, c;
        repeat (3) tick();
        chk("rst_flags", {cfg_ready, cfg_err, busy, mem_we, mem_re, eng_di_en, out_valid, out_last}, 8'h80);
        chk("rst_eng_sel", eng_sel, 0);
        chk("rst_pass_idx", pass_idx, 0);
        chk("rst_addrs", {mem_waddr, mem_raddr}, 0);
        rst = 1'b0;
        repeat (2) tick();

        run_frame("n30_d4", 1, 1, 1, 4, 1'b0, 1'b0);
        run_frame("n30_d1_gappy", 1, 1, 1, 1, 1'b1, 1'b1);
        run_frame("n8_r2_only", 3, 0, 0, 3, 1'b0, 1'b0);
        run_frame("n1", 0, 0, 0, 2, 1'b0, 1'b0);

        reject("rej_2304", 8, 2, 0);
        reject("rej_2187", 0, 7, 0);
        reject("rej_huge", 15, 7, 2);

        // Abort in the middle of the radix-3 pass
        d_lat = 4;
        start_cfg(1, 1, 1);
        do_load(30, 1'b0, 1'b0, k);
        k = 0;
        while (pass_idx != 2'd2 && k < 2000) begin tick(); k++; end
        chk("abort_reached_r3", pass_idx, 2);
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_re", mem_re, 0);
        chk("abort_we", mem_we, 0);
        chk("abort_di", eng_di_en, 0);
        chk("abort_eng_sel", eng_sel, 0);
        chk("abort_cfg_ready", cfg_ready, 1);
        clear_logs();
        repeat (8) tick();
        chk("abort_quiet_wr", wlog.size(), 0);
        chk("abort_quiet_rd", rlog.size(), 0);
        run_frame("after_abort", 1, 1, 1, 2, 1'b0, 1'b0);

        run_frame("n2048_max", 11, 0, 0, 1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            a = $urandom_range(0, 4);
            b = $urandom_range(0, 2);
            c = $urandom_range(0, 1);
            run_frame($sformatf("rand%0d_a%0d_b%0d_c%0d", r, a, b, c), a, b, c,
                      $urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        reject("rej_rand", $urandom_range(12, 15), $urandom_range(0, 7), $urandom_range(0, 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
